// File: rtl/main_driver.sv
// main_driver: initiator for the `main` compute unit handshake.
// Takes one command per transaction from an upstream valid/ready port,
// issues it with a one-cycle start pulse, waits out the unit's busy cycle,
// captures the result and offers it downstream on a valid/ready port.
//
// Ports:
//   clk, rst            clock (rising edge), async active-low reset
//   req_valid/req_ready upstream command handshake; req_mode, req_data payload
//   on, x, start        mode, operand and issue pulse to the compute unit
//   b, y                unit busy and result (result valid when b falls)
//   rsp_valid/rsp_ready downstream response handshake; rsp_data, rsp_err payload
//   busy                driver not idle
//   done_cnt            completed responses, wraps modulo 2^CNT_WIDTH
//
// Build option: define MAIN_DRIVER_TIMEOUT_EN to abort a transaction that spends
// TIMEOUT_CYCLES cycles waiting on the unit; it is answered with rsp_err=1.
module main_driver #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned CNT_WIDTH      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_mode,
  input  logic [WIDTH-1:0]     req_data,
  output logic [1:0]           on,
  output logic [WIDTH-1:0]     x,
  output logic                 start,
  input  logic                 b,
  input  logic [WIDTH-1:0]     y,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_data,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] done_cnt
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_HOLD      = 3'd4
  } state_t;

  // A zero timeout would make every issued command abort immediately.
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("main_driver: TIMEOUT_CYCLES must be at least 1");
  end

  state_t               state_q, state_d;
  logic [1:0]           mode_q, mode_d;
  logic [WIDTH-1:0]     data_q, data_d;

  logic                 req_ready_d;
  logic [1:0]           on_d;
  logic [WIDTH-1:0]     x_d;
  logic                 start_d;
  logic                 rsp_valid_d;
  logic [WIDTH-1:0]     rsp_data_d;
  logic                 rsp_err_d;
  logic                 busy_d;
  logic [CNT_WIDTH-1:0] done_cnt_d;
  logic                 issuing_d;

`ifdef MAIN_DRIVER_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      mode_q    <= 2'd0;
      data_q    <= '0;
      req_ready <= 1'b1;
      on        <= 2'd0;
      x         <= '0;
      start     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      done_cnt  <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      data_q    <= data_d;
      req_ready <= req_ready_d;
      on        <= on_d;
      x         <= x_d;
      start     <= start_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      rsp_err   <= rsp_err_d;
      busy      <= busy_d;
      done_cnt  <= done_cnt_d;
    end
  end

`ifdef MAIN_DRIVER_TIMEOUT_EN
  // Cycles spent waiting on the unit for the current command.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  // Next-state logic; outputs are decoded from the next state so they
  // change on the same edge as the state register.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    data_d      = data_q;
    rsp_data_d  = rsp_data;
    rsp_err_d   = rsp_err;
    done_cnt_d  = done_cnt;
    req_ready_d = 1'b0;
    on_d        = 2'd0;
    x_d         = '0;
    start_d     = 1'b0;
    rsp_valid_d = 1'b0;
    busy_d      = 1'b0;
    issuing_d   = 1'b0;
`ifdef MAIN_DRIVER_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          mode_d = req_mode;
          data_d = req_data;
          if (req_mode != 2'd0) begin
            state_d = S_ISSUE;
          end else begin
            // Mode 0 is not a legal command: answer with an error, issue nothing.
            state_d    = S_HOLD;
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_BUSY;
`ifdef MAIN_DRIVER_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      S_WAIT_BUSY: begin
        // b is sampled only here, so a stale busy seen during ISSUE is ignored.
        if (b) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (!b) begin
          state_d    = S_HOLD;
          rsp_data_d = y;
          rsp_err_d  = 1'b0;
        end
      end
      S_HOLD: begin
        if (rsp_ready) begin
          state_d    = S_IDLE;
          done_cnt_d = done_cnt + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef MAIN_DRIVER_TIMEOUT_EN
    // A completion on the same edge as the limit takes precedence.
    if ((state_q == S_WAIT_BUSY || state_q == S_WAIT_DONE) && state_d != S_HOLD) begin
      if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        state_d    = S_HOLD;
        rsp_err_d  = 1'b1;
        rsp_data_d = '0;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
`endif

    issuing_d   = (state_d == S_ISSUE) || (state_d == S_WAIT_BUSY) ||
                  (state_d == S_WAIT_DONE);
    on_d        = issuing_d ? mode_d : 2'd0;
    x_d         = issuing_d ? data_d : '0;
    start_d     = (state_d == S_ISSUE);
    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    rsp_valid_d = (state_d == S_HOLD);
  end

endmodule

// File: tb/tb_main_driver.sv
// Randomised scoreboard bench for main_driver with a behavioural compute unit.
module tb_main_driver;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_mode = 2'd0;
  logic [W-1:0]  req_data = '0;
  logic [1:0]    on;
  logic [W-1:0]  x;
  logic          start;
  logic          b = 1'b0;
  logic [W-1:0]  y = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [W-1:0]  rsp_data;
  logic          rsp_err;
  logic          busy;
  logic [CW-1:0] done_cnt;

  always #5 clk = ~clk;

  main_driver #(.WIDTH(W), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode), .req_data(req_data),
    .on(on), .x(x), .start(start), .b(b), .y(y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .done_cnt(done_cnt)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [8:0]    exp_q[$];   // {err, data} per accepted command
  logic [9:0]    cmd_q[$];   // {mode, data} per command that must reach the unit
  logic [CW-1:0] exp_cnt = '0;
  int            rr_ctl = 2;     // 0/1 force rsp_ready, 2 random
  int            unit_mode = 0;  // 0 normal, 1 never raises b, 2 keeps b high
  bit            fixed_t = 1'b0;
  int            start_n = 0;
  int            acc_edge = 0;
  int            last_rsp_edge = 0;
  bit            prev_start = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expire(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // Compute unit function: result is twice the operand, mixed with the mode.
  function automatic logic [7:0] unit_fn(input logic [1:0] m, input logic [7:0] d);
    logic [7:0] k;
    k = {6'd0, m} * 8'h11;
    if (m == 2'd3) k = 8'h00;
    return {d[6:0], 1'b0} ^ k;
  endfunction

  // Downstream ready generator.
  initial forever begin
    @(posedge clk); #1;
    rsp_ready = (rr_ctl == 2) ? ($urandom_range(0, 3) != 0) : rr_ctl[0];
  end

  // Behavioural compute unit; also checks what the driver issues.
  initial begin : unit_model
    logic [1:0] on_c;
    logic [7:0] x_c;
    logic [9:0] cmd;
    int lat, hold;
    forever begin
      @(negedge clk);
      if (rst && start) begin
        start_n = cyc + 1;
        on_c = on;
        x_c  = x;
        if (cmd_q.size() == 0) begin
          expire("unexpected_start");
        end else begin
          cmd = cmd_q.pop_front();
          chk("start_on", 32'(on_c), 32'(cmd[9:8]));
          chk("start_x", 32'(x_c), 32'(cmd[7:0]));
        end
        lat  = fixed_t ? 0 : $urandom_range(0, 2);
        hold = fixed_t ? 4 : $urandom_range(1, 4);
        @(posedge clk); #1;
        if (unit_mode != 1) begin
          for (int i = 0; i < lat; i++) begin @(posedge clk); #1; end
          b = 1'b1;
          y = 8'($urandom);
          for (int i = 0; i < hold; i++) begin @(posedge clk); #1; end
          while (unit_mode == 2) begin @(posedge clk); #1; end
          b = 1'b0;
          y = unit_fn(on_c, x_c);
          @(posedge clk); #1;
          y = 8'($urandom);   // result is only guaranteed on the falling edge of b
        end
      end
    end
  end

  // Response monitor / scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      chk("done_cnt", 32'(done_cnt), 32'(exp_cnt));
      chk("req_ready_idle", 32'(req_ready), 32'(!busy));
      if (start && prev_start) chk("start_one_cycle", 32'(1), 32'(0));
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          expire("unexpected_rsp");
        end else begin
          chk("rsp_data", 32'(rsp_data), 32'(exp_q[0][7:0]));
          chk("rsp_err", 32'(rsp_err), 32'(exp_q[0][8]));
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            exp_cnt = exp_cnt + 8'd1;
            last_rsp_edge = cyc + 1;
          end
        end
      end
      prev_start = start;
    end else begin
      prev_start = 1'b0;
    end
  end

  task automatic send(input logic [1:0] m, input logic [7:0] d, input bit tmo);
    bit ok = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_mode  = m;
    req_data  = d;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      expire("req_accept");
      req_valid = 1'b0;
      return;
    end
    acc_edge = cyc + 1;
    if (m == 2'd0 || tmo) exp_q.push_back({1'b1, 8'h00});
    else                  exp_q.push_back({1'b0, unit_fn(m, d)});
    if (m != 2'd0) cmd_q.push_back({m, d});
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_mode  = 2'($urandom);
    req_data  = 8'($urandom);
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0 && !b) begin ok = 1'b1; break; end
    end
    if (!ok) expire(name);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'(1));
    chk({tag, "_on"}, 32'(on), 32'(0));
    chk({tag, "_x"}, 32'(x), 32'(0));
    chk({tag, "_start"}, 32'(start), 32'(0));
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
    chk({tag, "_rsp_data"}, 32'(rsp_data), 32'(0));
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'(0));
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    exp_q.delete();
    cmd_q.delete();
    exp_cnt   = '0;
    unit_mode = 0;
    repeat (3) @(negedge clk);
    chk_reset_vals(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_rsp_valid(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1'b1; break; end
    end
    if (!ok) expire(name);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t_edge;
    bit ok;
    #3;
    // Reset values, then idle with no requests.
    do_reset("rst");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_start", 32'(start), 32'(0));
      chk("idle_busy", 32'(busy), 32'(0));
    end

    // Directed command: mode 3, operand 0x19, unit busy for 4 cycles.
    fixed_t = 1'b1;
    send(2'd3, 8'h19, 1'b0);
    wait_idle("t2_idle");
    chk("t2_done_cnt", 32'(done_cnt), 32'(1));
    fixed_t = 1'b0;

    // Illegal mode: error response on the next cycle, nothing issued.
    rr_ctl = 0;
    send(2'd0, 8'h55, 1'b0);
    chk("t3_start", 32'(start), 32'(0));
    chk("t3_rsp_valid", 32'(rsp_valid), 32'(1));
    chk("t3_rsp_err", 32'(rsp_err), 32'(1));
    chk("t3_rsp_data", 32'(rsp_data), 32'(0));
    rr_ctl = 2;
    wait_idle("t3_idle");

    // Backpressure with a request pending; accept lands one cycle after IDLE.
    rr_ctl = 0;
    send(2'd2, 8'h40, 1'b0);
    wait_rsp_valid("t4_rsp");
    fork
      send(2'd1, 8'hA5, 1'b0);
      begin
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          chk("t4_hold_valid", 32'(rsp_valid), 32'(1));
          chk("t4_hold_req_ready", 32'(req_ready), 32'(0));
          chk("t4_hold_data", 32'(rsp_data), 32'(unit_fn(2'd2, 8'h40)));
        end
        rr_ctl = 1;
      end
    join
    chk("t4_bubble", 32'(acc_edge), 32'(last_rsp_edge + 1));
    rr_ctl = 2;
    wait_idle("t4_idle");

    // Random traffic.
    for (int n = 0; n < 40; n++) send(2'($urandom), 8'($urandom), 1'b0);
    wait_idle("rand_idle");

    // Unit never answers.
`ifdef MAIN_DRIVER_TIMEOUT_EN
    unit_mode = 1;
    rr_ctl = 0;
    send(2'd1, 8'h3C, 1'b1);
    wait_rsp_valid("t5_rsp");
    chk("t5_timeout_latency", 32'(cyc - start_n), 32'(8));
    chk("t5_on", 32'(on), 32'(0));
    chk("t5_err", 32'(rsp_err), 32'(1));
    chk("t5_data", 32'(rsp_data), 32'(0));
    rr_ctl = 2;
    unit_mode = 0;
    wait_idle("t5_idle");
    do_reset("t5rst");
`else
    unit_mode = 1;
    send(2'd1, 8'h3C, 1'b0);
    repeat (100) @(negedge clk);
    chk("t5_busy", 32'(busy), 32'(1));
    chk("t5_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("t5_req_ready", 32'(req_ready), 32'(0));
    chk("t5_on", 32'(on), 32'(1));
    chk("t5_x", 32'(x), 32'(8'h3C));
    do_reset("t5rst");
`endif

    // Asynchronous reset while waiting for the unit to finish.
    unit_mode = 2;
    send(2'd2, 8'h77, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (b) begin ok = 1'b1; break; end
    end
    if (!ok) expire("t6_b_rise");
    @(negedge clk);
    chk("t6_pre_busy", 32'(busy), 32'(1));
    chk("t6_pre_on", 32'(on), 32'(2));
    #2;
    t_edge = cyc;
    rst = 1'b0;
    exp_q.delete();
    cmd_q.delete();
    exp_cnt = '0;
    #1;
    chk_reset_vals("t6");
    chk("t6_no_edge", 32'(cyc), 32'(t_edge));
    unit_mode = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_idle("t6_idle");

    // done_cnt wraps after 256 responses.
    for (int n = 0; n < 255; n++) send(2'($urandom), 8'($urandom), 1'b0);
    wait_idle("wrap_idle_a");
    chk("wrap_255", 32'(done_cnt), 32'(255));
    send(2'd1, 8'h81, 1'b0);
    wait_idle("wrap_idle_b");
    chk("wrap_0", 32'(done_cnt), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/main_driver.md
Name: main_driver

Overview:
- Initiator side of the compute-unit handshake (`on`/`x`/`start` out, `b`/`y` back). Accepts one command per transaction from an upstream valid/ready port and issues it to the unit with a one-cycle `start` pulse.
- Waits for the unit's busy cycle to complete, then captures `y`. Presents the captured result downstream on a valid/ready port.
- Sits between the test/control logic and the `main` compute unit, replacing hand-driven stimulus.

Parameters:
- WIDTH, 8, operand/result width (`x`, `y`, `req_data`, `rsp_data`)
- CNT_WIDTH, 8, width of completed-transaction counter
- TIMEOUT_CYCLES, 64, max cycles in WAIT_BUSY+WAIT_DONE before abort (TIMEOUT_EN only)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- req_valid  in  1  upstream command valid
- req_ready  out  1  driver can accept command
- req_mode  in  2  regime for unit; 0 = off (illegal command)
- req_data  in  WIDTH  operand
- on  out  2  mode to compute unit
- x  out  WIDTH  operand to compute unit
- start  out  1  one-cycle issue pulse to compute unit
- b  in  1  compute unit busy
- y  in  WIDTH  compute unit result, valid on busy falling edge
- rsp_valid  out  1  result valid
- rsp_ready  in  1  downstream accepts result
- rsp_data  out  WIDTH  captured result
- rsp_err  out  1  1 = illegal mode or timeout; rsp_data = 0 in that case
- busy  out  1  driver not in IDLE
- done_cnt  out  CNT_WIDTH  count of completed responses

Behaviour:
- Reset (rst=0, async): state IDLE. Outputs: req_ready=1, on=0, x=0, start=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, done_cnt=0.
- All outputs are registered.
- IDLE
  - req_ready=1; `on` and `x` = 0.
  - On req_valid & req_ready: latch mode and data.
  - If mode≠0, go to ISSUE.
  - If mode=0, go to HOLD with rsp_err=1, rsp_data=0; nothing is issued to the unit.
- ISSUE
  - Exactly one cycle.
  - start=1, on=latched mode, x=latched data.
  - Then go to WAIT_BUSY.
- WAIT_BUSY
  - start=0; on/x held.
  - When b=1, go to WAIT_DONE.
- WAIT_DONE
  - on/x held.
  - In the first cycle sampling b=0: capture y into rsp_data, set rsp_err=0, go to HOLD.
- HOLD
  - rsp_valid=1; on=0, x=0.
  - rsp_data/rsp_err stable until accepted.
  - On rsp_ready: done_cnt+=1 (wraps modulo 2^CNT_WIDTH), rsp_valid=0, go to IDLE.
- req_ready=0 in every state except IDLE. A request arriving during HOLD is not accepted until the cycle after the response is consumed, giving one bubble minimum between transactions.
- busy = (state≠IDLE).
- rsp_ready is ignored outside HOLD.
- b already high in ISSUE: ignored. Only WAIT_BUSY samples it, so a stale busy from a previous op must clear first.
- Reset mid-transaction returns to IDLE immediately with all outputs at reset values. The unit sees on=0 with no further start.

Optional Feature:
- Macro: `MAIN_DRIVER_TIMEOUT_EN`
- Defined:
  - A counter clears on entering WAIT_BUSY and increments each cycle in WAIT_BUSY or WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES, go to HOLD with rsp_err=1, rsp_data=0, and on forced to 0.
  - A timeout is counted in done_cnt like a normal response.
- Undefined: no counter; WAIT_BUSY/WAIT_DONE wait indefinitely. rsp_err is raised only for mode=0.

Test Plan:
1. Reset → all outputs at reset values, req_ready=1. Release reset, hold req_valid=0 for 5 cycles → no start pulse, busy=0.
2. Request mode=3, data=0x19; unit model raises b 1 cycle after start, holds it 4 cycles, y=0x32 → start high exactly 1 cycle with on=3, x=0x19; rsp_valid with rsp_data=0x32, rsp_err=0; done_cnt=1 after rsp_ready.
3. Request mode=0, data=0x55 → no start; next cycle rsp_valid=1, rsp_err=1, rsp_data=0.
4. Response backpressure: rsp_ready=0 for 6 cycles with a new req_valid pending → rsp_data stable, req_ready=0. Raise rsp_ready → new request accepted the cycle after return to IDLE.
5. With `MAIN_DRIVER_TIMEOUT_EN`, TIMEOUT_CYCLES=8, unit never raises b → rsp_err=1 exactly 8 cycles after WAIT_BUSY entry, on=0. Without the macro → driver still in WAIT_BUSY after 100 cycles.
6. Assert rst=0 asynchronously during WAIT_DONE → outputs reset immediately, without waiting for a clock edge. done_cnt 255→0 wrap is checked after 256 transactions.
